// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file write-port arbiter (ALU vs load) with a pending-write scoreboard and decode stall
//   clk, rst (async, active-low)
//   alu_valid/alu_rd/alu_data -> alu_ready ; mem_valid/mem_rd/mem_data -> mem_ready
//   iss_valid/iss_rd mark a destination pending ; rs1/rs2 -> stall
//   rd_we/writeReg/writeData : registered register-file write
//   `define WB_FWD_EN adds fwd1_hit/fwd2_hit/fwd_data and lets a hit bypass the stall
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        stall,
`ifdef WB_FWD_EN
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd_data,
`endif
    output logic        rd_we,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;
    logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
    logic grant, hit1, hit2;
    logic [4:0] win_rd;
    logic [31:0] win_data;
    // the ALU only loses to a competing load until it has lost LIM times in a row
    assign alu_ready = rst && alu_valid && (!mem_valid || starve_cnt == LIM);
    assign mem_ready = rst && mem_valid && !alu_ready;
    assign grant = alu_ready || mem_ready;
    assign win_rd = alu_ready ? alu_rd : mem_rd;
    assign win_data = alu_ready ? alu_data : mem_data;
    assign set_mask = (iss_valid && iss_rd != 5'd0) ? NUM_REGS'(1) << iss_rd : '0;
    assign clr_mask = rd_we ? NUM_REGS'(1) << writeReg : '0;
`ifdef WB_FWD_EN
    assign hit1 = rd_we && writeReg == rs1 && rs1 != 5'd0;
    assign hit2 = rd_we && writeReg == rs2 && rs2 != 5'd0;
    assign fwd1_hit = hit1;
    assign fwd2_hit = hit2;
    assign fwd_data = writeData;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif
    assign stall = (rs1 != 5'd0 && pending[rs1] && !hit1) || (rs2 != 5'd0 && pending[rs2] && !hit2);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            rd_we <= 1'b0;
            writeReg <= '0;
            writeData <= '0;
            pending <= '0;
        end else begin
            starve_cnt <= (!alu_valid || alu_ready) ? '0 : (mem_ready && starve_cnt != LIM) ? starve_cnt + 4'd1 : starve_cnt;
            rd_we <= grant && win_rd != 5'd0;
            if (grant) begin
                writeReg <= win_rd;
                writeData <= win_data;
            end
            // set is applied after clear so a same-edge reissue keeps the register pending
            pending <= ((pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
    logic clk = 1'b0, rst;
    logic alu_valid, mem_valid, iss_valid;
    logic [4:0] alu_rd, mem_rd, iss_rd, rs1, rs2;
    logic [31:0] alu_data, mem_data;
    logic alu_ready, mem_ready, stall, rd_we;
    logic [4:0] writeReg;
    logic [31:0] writeData;
`ifdef WB_FWD_EN
    logic fwd1_hit, fwd2_hit;
    logic [31:0] fwd_data;
`endif
    typedef struct packed {logic we; logic [4:0] rd; logic [31:0] d;} wb_t;
    wb_t q[$];
    logic [4:0] last_rd;
    logic [31:0] last_d;
    int n_tests = 0, n_fail = 0;
    logic [3:0] exp_sc[4];
    logic exp_alu[4];
    always #5 clk = ~clk;
    wb_port_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .stall(stall),
`ifdef WB_FWD_EN
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
`endif
        .rd_we(rd_we), .writeReg(writeReg), .writeData(writeData)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input logic ea, input logic em);
        wb_t e;
        @(negedge clk);
        chk("alu_ready", 32'(alu_ready), 32'(ea));
        chk("mem_ready", 32'(mem_ready), 32'(em));
        if (ea) e = '{we: alu_rd != 5'd0, rd: alu_rd, d: alu_data};
        else if (em) e = '{we: mem_rd != 5'd0, rd: mem_rd, d: mem_data};
        else e = '{we: 1'b0, rd: last_rd, d: last_d};
        last_rd = e.rd;
        last_d = e.d;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("rd_we", 32'(rd_we), 32'(e.we));
        chk("writeReg", 32'(writeReg), 32'(e.rd));
        chk("writeData", writeData, e.d);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        exp_sc = '{4'd1, 4'd2, 4'd3, 4'd0};
        exp_alu = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b0;
        {alu_valid, mem_valid, iss_valid} = '0;
        {alu_rd, mem_rd, iss_rd, rs1, rs2} = '0;
        alu_data = '0;
        mem_data = '0;
        last_rd = '0;
        last_d = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // reset mid-transfer
        iss_valid = 1'b1; iss_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
        cyc(1'b1, 1'b0);
        iss_valid = 1'b0; rs1 = 5'd9;
        alu_rd = 5'd4; alu_data = 32'h0000_0444;
        #1 chk("stall_pre_reset", 32'(stall), 32'd1);
        rst = 1'b0;
        q.delete(); last_rd = '0; last_d = '0;
        #1;
        chk("reset_rd_we", 32'(rd_we), 32'd0);
        chk("reset_writeReg", 32'(writeReg), 32'd0);
        chk("reset_writeData", writeData, 32'd0);
        chk("reset_pending", dut.pending, 32'd0);
        chk("reset_alu_ready", 32'(alu_ready), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        #1 rst = 1'b1;
        cyc(1'b1, 1'b0);
        // ALU only
        alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; rs1 = 5'd0;
        cyc(1'b1, 1'b0);
        alu_valid = 1'b0;
        cyc(1'b0, 1'b0);
        // contention: mem, mem, mem, ALU repeating
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A0_0000;
        mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'h3000_0000;
        for (int i = 0; i < 8; i++) begin
            cyc(exp_alu[i % 4], !exp_alu[i % 4]);
            chk("starve_cnt", 32'(dut.starve_cnt), 32'(exp_sc[i % 4]));
            if (exp_alu[i % 4]) alu_data = alu_data + 32'd1;
            else mem_data = mem_data + 32'd1;
        end
        // x0 write
        alu_valid = 1'b0;
        mem_rd = 5'd0; mem_data = 32'h0000_1234;
        cyc(1'b0, 1'b1);
        mem_valid = 1'b0;
        // scoreboard
        iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
        cyc(1'b0, 1'b0);
        iss_valid = 1'b0;
        #1 chk("stall_pending", 32'(stall), 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
        cyc(1'b1, 1'b0);
        alu_valid = 1'b0;
`ifdef WB_FWD_EN
        chk("stall_fwd", 32'(stall), 32'd0);
        chk("fwd1_hit", 32'(fwd1_hit), 32'd1);
        chk("fwd_data", fwd_data, 32'h0000_0077);
`else
        chk("stall_write_cycle", 32'(stall), 32'd1);
`endif
        cyc(1'b0, 1'b0);
        chk("stall_cleared", 32'(stall), 32'd0);
        rs1 = 5'd0; rs2 = 5'd7;
        alu_valid = 1'b1; alu_data = 32'h0000_0088;
        cyc(1'b1, 1'b0);
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        cyc(1'b0, 1'b0);
        iss_valid = 1'b0;
        chk("pending7_set_wins", 32'(dut.pending[7]), 32'd1);
        chk("stall_rs2", 32'(stall), 32'd1);
        iss_valid = 1'b1; iss_rd = 5'd0; rs2 = 5'd0;
        cyc(1'b0, 1'b0);
        iss_valid = 1'b0;
        chk("pending0_zero", 32'(dut.pending[0]), 32'd0);
        chk("stall_x0_src", 32'(stall), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Writeback controller for the 32x32 register file's single write port. It shares the port between the ALU result path and the load (data-memory) return path using valid/ready handshakes. It registers the winning write onto rd_we/writeReg/writeData. It also keeps a per-register pending scoreboard that raises a read-hazard stall to the decode stage.

Parameters:
STARVE_LIMIT, 3, consecutive cycles the ALU may lose arbitration before it is forced to win (legal range 1..15)
NUM_REGS, 32, register count; scoreboard width; index width fixed at 5 bits

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU writeback request
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid  input  1  load writeback request
mem_rd  input  5  load destination register
mem_data  input  32  load data
mem_ready  output  1  load request accepted this cycle
iss_valid  input  1  instruction issued with a register destination
iss_rd  input  5  destination of issued instruction
rs1  input  5  decode source 1 (instruction[19:15])
rs2  input  5  decode source 2 (instruction[24:20])
stall  output  1  decode must hold: a source has a pending write
rd_we  output  1  register-file write enable
writeReg  output  5  register-file write index
writeData  output  32  register-file write data

Behaviour:
- Reset (rst low, asynchronous): rd_we=0, writeReg=0, writeData=0, pending=0, starve_cnt=0. alu_ready, mem_ready and stall are 0 while rst is low. Requests in flight are dropped; requesters re-present after reset.
- Handshake: a transfer occurs when valid&ready are both high on a posedge. Requesters hold valid, rd and data stable until accepted. ready is combinational from the valids and starve_cnt. At most one ready is high per cycle.
- Arbitration:
  - mem wins by default.
  - ALU wins when mem_valid=0, or when starve_cnt==STARVE_LIMIT.
  - Neither valid -> no grant.
- starve_cnt:
  - +1 when alu_valid&mem_valid and mem is granted.
  - Cleared when the ALU is granted or alu_valid=0.
  - Saturates at STARVE_LIMIT.
- Output stage, 1-cycle latency from the accept edge:
  - writeReg/writeData <= the winner's rd/data.
  - rd_we <= (grant && rd!=0).
  - No grant -> rd_we<=0, writeReg/writeData hold their previous values.
  - A write to x0 completes the handshake but never asserts rd_we.
- Scoreboard pending[31:0], pending[0] is always 0:
  - Set on iss_valid when iss_rd!=0.
  - Cleared on the edge where rd_we=1 for writeReg, i.e. the same edge the register file stores the data.
  - Set and clear of the same index on the same edge: set wins.
- stall = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]), combinational.
- Back-to-back grants are allowed every cycle: full throughput of one write per cycle.

Optional Feature:
WB_FWD_EN.
- Defined: adds outputs fwd1_hit, fwd2_hit (1 bit) and fwd_data (32 bit).
  - fwdN_hit = rd_we && writeReg==rsN && rsN!=0.
  - fwd_data = writeData.
  - stall ignores pending[rsN] whenever fwdN_hit=1, saving one stall cycle per dependency.
- Undefined: these ports do not exist and stall follows the base rule only.

Test Plan:
1. Reset: assert rst=0 mid-transfer with alu_valid=1 -> all outputs 0, pending=0. After release, alu_ready=1 and rd_we=1 one cycle after the accept edge.
2. ALU only: alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle. Next cycle rd_we=1, writeReg=5, writeData=0xDEADBEEF.
3. Contention: STARVE_LIMIT=3, both valid continuously with distinct rd.
   - Grants are mem,mem,mem,ALU, then the pattern repeats.
   - starve_cnt reads 1,2,3,0.
4. x0 write: mem_rd=0, mem_data=0x1234 -> mem_ready=1, and rd_we stays 0 the following cycle.
5. Scoreboard: iss_rd=7, then rs1=7 -> stall=1. It stays 1 until the edge where rd_we=1/writeReg=7 is sampled, then 0 (base build). Same-edge iss_rd=7 with write to 7 -> pending[7] stays 1.
6. WB_FWD_EN: same as 5 -> stall=0 in the rd_we=1 cycle, fwd1_hit=1, fwd_data equals the written value.
